// File: rtl/lix_shr_sk_if.sv
// Handshake bundle for lix_shr_sk: upstream ready/valid, downstream ready/valid
// and the credit-usage readout. The DUT takes the slave view.
interface lix_shr_sk_if #(
  parameter int W = 32,
  parameter int D = 3
);
  localparam int CW = $clog2(D + 1);

  logic          i_vld;
  logic          o_rdy;
  logic [W-1:0]  i_x;
  logic          o_vld;
  logic          i_rdy;
  logic [W-1:0]  o_z;
  logic [CW-1:0] o_used;

  modport slave (
    input  i_vld, i_x, i_rdy,
    output o_rdy, o_vld, o_z, o_used
  );

  modport master (
    output i_vld, i_x, i_rdy,
    input  o_rdy, o_vld, o_z, o_used
  );
endinterface

// File: rtl/lix_shr_sk.sv
// Credit-controlled elastic delay line: N non-stalling register stages feeding a
// D-entry FIFO. A word is admitted only when a FIFO slot is guaranteed for it.
module lix_shr_sk #(
  parameter int W = 32,
  parameter int N = 2,
  parameter int D = 3
) (
  input logic        clk_i,
  input logic        rst_i,
  lix_shr_sk_if.slave bus
);
  localparam int CW = $clog2(D + 1);
  localparam int PW = (D > 1) ? $clog2(D) : 1;

  logic          acc;
  logic          pop;
  logic          wr;
  logic [CW-1:0] used_reg;
  logic [CW-1:0] count_reg;
  logic [PW-1:0] wr_ptr_reg;
  logic [PW-1:0] rd_ptr_reg;
  logic [N:1]    v_reg;
  logic [W-1:0]  d_reg [1:N];
  logic [W-1:0]  mem [0:D-1];

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(D - 1)) ? '0 : p + 1'b1;
  endfunction

  // Admission depends only on the registered credit count, never on i_rdy.
  assign bus.o_rdy  = (used_reg < CW'(D));
  assign acc        = bus.i_vld & bus.o_rdy;
  assign pop        = bus.o_vld & bus.i_rdy;
  assign wr         = v_reg[N];
  assign bus.o_vld  = (count_reg != '0);
  assign bus.o_z    = bus.o_vld ? mem[rd_ptr_reg] : '0;
  assign bus.o_used = used_reg;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      v_reg[1] <= 1'b0;
      d_reg[1] <= '0;
    end else begin
      v_reg[1] <= acc;
      if (acc) d_reg[1] <= bus.i_x;
    end
  end

  // Data only moves behind a valid bit so idle stages keep their shares still.
  generate
    for (genvar gi = 1; gi < N; gi++) begin : g_stage
      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          v_reg[gi+1] <= 1'b0;
          d_reg[gi+1] <= '0;
        end else begin
          v_reg[gi+1] <= v_reg[gi];
          if (v_reg[gi]) d_reg[gi+1] <= d_reg[gi];
        end
      end
    end
  endgenerate

  always_ff @(posedge clk_i) begin
    if (wr) mem[wr_ptr_reg] <= d_reg[N];
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      used_reg   <= '0;
    end else begin
      if (wr)  wr_ptr_reg <= ptr_inc(wr_ptr_reg);
      if (pop) rd_ptr_reg <= ptr_inc(rd_ptr_reg);
      case ({wr, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
      case ({acc, pop})
        2'b10:   used_reg <= used_reg + 1'b1;
        2'b01:   used_reg <= used_reg - 1'b1;
        default: used_reg <= used_reg;
      endcase
    end
  end

  a_used_over:  assert property (@(posedge clk_i) disable iff (rst_i)
                                 !(acc && !pop && used_reg == CW'(D)));
  a_used_under: assert property (@(posedge clk_i) disable iff (rst_i)
                                 !(pop && !acc && used_reg == '0));
  a_fifo_full:  assert property (@(posedge clk_i) disable iff (rst_i)
                                 !(wr && !pop && count_reg == CW'(D)));
endmodule

// File: tb/tb_lix_shr_sk.sv
// Bench for lix_shr_sk: fixed vector tables, directed corner sequences and
// random traffic compared against a queue-based model of the credit rules.
module tb_lix_shr_sk;
  localparam int W = 32;
  localparam int N = 2;
  localparam int D = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  lix_shr_sk_if #(.W(W), .D(D)) bus0 ();
  lix_shr_sk_if #(.W(W), .D(1)) bus1 ();

  lix_shr_sk #(.W(W), .N(N), .D(D)) u_dut  (.clk_i(clk), .rst_i(rst), .bus(bus0));
  lix_shr_sk #(.W(W), .N(N), .D(1)) u_dut1 (.clk_i(clk), .rst_i(rst), .bus(bus1));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: queue of accepted words with their acceptance cycle.
  typedef struct {
    logic [31:0] data;
    int          t;
  } ent_t;
  ent_t q[$];
  int   cyc;

  task automatic model_cycle(input logic vld, input logic [31:0] x, input logic rdy_in,
                             input string tag, output logic accepted);
    logic        hv;
    logic [31:0] hz;
    logic        rdy_exp;
    @(negedge clk);
    bus0.i_vld = vld;
    bus0.i_x   = x;
    bus0.i_rdy = rdy_in;
    #1;
    hv      = (q.size() > 0) && (q[0].t + N + 1 <= cyc);
    hz      = hv ? q[0].data : 32'h0;
    rdy_exp = (q.size() < D);
    check({tag, ".o_vld"},  bus0.o_vld,  hv);
    check({tag, ".o_z"},    bus0.o_z,    hz);
    check({tag, ".o_used"}, bus0.o_used, q.size());
    check({tag, ".o_rdy"},  bus0.o_rdy,  rdy_exp);
    if (hv && rdy_in) begin
      $display("%s cyc %0d: pop 0x%08h", tag, cyc, hz);
      void'(q.pop_front());
    end
    accepted = vld && rdy_exp;
    if (accepted) q.push_back('{x, cyc});
    cyc++;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus0.i_vld = 1'b0; bus0.i_x = '0; bus0.i_rdy = 1'b1;
    bus1.i_vld = 1'b0; bus1.i_x = '0; bus1.i_rdy = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    q.delete();
    cyc = 0;
  endtask

  task automatic drain(input string tag, input bit toggle);
    logic acc_dummy;
    int   k = 0;
    while (q.size() > 0 && k < 80) begin
      model_cycle(1'b0, 32'h0, toggle ? logic'(k % 2 == 0) : 1'b1, tag, acc_dummy);
      k++;
    end
    n_checks++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL %s.drain: %0d words left, expected 0", tag, q.size());
    end
  endtask

  typedef struct {
    bit          rst_before;
    logic        vld;
    logic [31:0] x;
    logic        rdy;
    logic        e_rdy;
    logic        e_vld;
    logic [31:0] e_z;
    logic [1:0]  e_used;
  } vec_t;
  vec_t tab[$];

  function automatic void add(bit r, logic v, logic [31:0] x, logic ri,
                              logic er, logic ev, logic [31:0] ez, logic [1:0] eu);
    tab.push_back('{r, v, x, ri, er, ev, ez, eu});
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        acc_f;
    int          sent;
    int          tries;
    int          peak;
    logic [31:0] rx;

    // Single word through an idle pipe.
    add(1, 1, 32'hA5A5_0001, 1, 1, 0, 32'h0, 0);
    add(0, 0, 32'h0, 1, 1, 0, 32'h0, 1);
    add(0, 0, 32'h0, 1, 1, 0, 32'h0, 1);
    add(0, 0, 32'h0, 1, 1, 1, 32'hA5A5_0001, 1);
    add(0, 0, 32'h0, 1, 1, 0, 32'h0, 0);
    add(0, 0, 32'h0, 1, 1, 0, 32'h0, 0);
    // Backpressure: i_vld held, i_x = cycle+1, i_rdy raised at cycle 8.
    add(1, 1, 32'd1, 0, 1, 0, 32'd0, 0);
    add(0, 1, 32'd2, 0, 1, 0, 32'd0, 1);
    add(0, 1, 32'd3, 0, 1, 0, 32'd0, 2);
    for (int c = 3; c < 8; c++) add(0, 1, 32'(c + 1), 0, 0, 1, 32'd1, 3);
    add(0, 1, 32'd9,  1, 0, 1, 32'd1,  3);
    add(0, 1, 32'd10, 1, 1, 1, 32'd2,  2);
    add(0, 1, 32'd11, 1, 1, 1, 32'd3,  2);
    add(0, 1, 32'd12, 1, 1, 0, 32'd0,  2);
    add(0, 1, 32'd13, 1, 0, 1, 32'd10, 3);

    do_reset();
    #1;
    check("reset.o_vld",  bus0.o_vld,  0);
    check("reset.o_z",    bus0.o_z,    0);
    check("reset.o_used", bus0.o_used, 0);
    check("reset.o_rdy",  bus0.o_rdy,  1);

    for (int i = 0; i < tab.size(); i++) begin
      if (tab[i].rst_before) do_reset();
      @(negedge clk);
      bus0.i_vld = tab[i].vld;
      bus0.i_x   = tab[i].x;
      bus0.i_rdy = tab[i].rdy;
      #1;
      $display("vec %0d: vld=%0b x=0x%08h rdy=%0b -> o_rdy=%0b o_vld=%0b o_z=0x%08h used=%0d",
               i, tab[i].vld, tab[i].x, tab[i].rdy, bus0.o_rdy, bus0.o_vld, bus0.o_z, bus0.o_used);
      check($sformatf("vec%0d.o_rdy", i),  bus0.o_rdy,  tab[i].e_rdy);
      check($sformatf("vec%0d.o_vld", i),  bus0.o_vld,  tab[i].e_vld);
      check($sformatf("vec%0d.o_z", i),    bus0.o_z,    tab[i].e_z);
      check($sformatf("vec%0d.o_used", i), bus0.o_used, tab[i].e_used);
    end

    // Streaming words 1..10 with the sink always ready.
    do_reset();
    sent = 0; tries = 0; peak = 0;
    while (sent < 10 && tries < 60) begin
      model_cycle(1'b1, 32'(sent + 1), 1'b1, "stream", acc_f);
      if (int'(bus0.o_used) > peak) peak = int'(bus0.o_used);
      if (acc_f) sent++;
      tries++;
    end
    check("stream.sent", sent, 10);
    drain("stream", 0);
    check("stream.peak_used", peak, D);

    // Seven words with the sink toggling: pointers wrap twice.
    do_reset();
    sent = 0; tries = 0;
    while (sent < 7 && tries < 60) begin
      model_cycle(1'b1, 32'(sent + 1), logic'(tries % 2 == 0), "wrap", acc_f);
      if (acc_f) sent++;
      tries++;
    end
    check("wrap.sent", sent, 7);
    drain("wrap", 1);

    // Reset pulse with one word queued and two in flight.
    do_reset();
    for (int i = 0; i < 3; i++) model_cycle(1'b1, 32'hBEEF_0000 + 32'(i), 1'b0, "midrst", acc_f);
    @(negedge clk);
    bus0.i_vld = 1'b0; bus0.i_rdy = 1'b0;
    #1;
    check("midrst.queued_vld", bus0.o_vld, 1);
    check("midrst.queued_z",   bus0.o_z,   32'hBEEF_0000);
    #1 rst = 1'b1;
    #1;
    check("midrst.o_vld",  bus0.o_vld,  0);
    check("midrst.o_z",    bus0.o_z,    0);
    check("midrst.o_used", bus0.o_used, 0);
    #1 rst = 1'b0;
    #1;
    check("midrst.o_rdy", bus0.o_rdy, 1);
    q.delete();
    cyc = 0;
    for (int i = 0; i < 8; i++) model_cycle(1'b0, 32'h0, 1'b1, "postrst", acc_f);

    // Random traffic against the model.
    do_reset();
    for (int i = 0; i < 400; i++) begin
      rx = $urandom;
      model_cycle(logic'($urandom_range(3, 0) != 0), rx, logic'($urandom_range(2, 0) != 0),
                  "rand", acc_f);
    end
    drain("rand", 0);

    // Depth-1 instance with both sides always willing.
    do_reset();
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      bus1.i_vld = 1'b1;
      bus1.i_rdy = 1'b1;
      bus1.i_x   = 32'(100 + k);
      #1;
      $display("d1 cyc %0d: o_rdy=%0b o_vld=%0b o_z=%0d used=%0d",
               k, bus1.o_rdy, bus1.o_vld, bus1.o_z, bus1.o_used);
      check($sformatf("d1.c%0d.o_rdy", k),  bus1.o_rdy,  (k % 4 == 0));
      check($sformatf("d1.c%0d.o_vld", k),  bus1.o_vld,  (k % 4 == 3));
      check($sformatf("d1.c%0d.o_z", k),    bus1.o_z,    (k % 4 == 3) ? 32'(100 + k - 3) : 32'h0);
      check($sformatf("d1.c%0d.o_used", k), bus1.o_used, (k % 4 == 0) ? 0 : 1);
    end
    bus1.i_vld = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
